shift_rotate_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator. It is the successor to the CADR fixed 32-bit combinational left rotator. The block generalises data width and pipeline depth. It adds logical-left, logical-right and arithmetic-right modes, a shifted-out carry bit, and a valid/ready handshake with backpressure. It sits between the M-source mux and the masker/ALU result path, and is also available to other datapaths needing multi-cycle shifts.

---
 rtl/shift_rotate_pipe.sv | 105 ++++++++++
 tb/tb_shift_rotate_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe: pipelined barrel rotator/shifter with carry-out and valid/ready backpressure
module shift_rotate_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   r,
    output logic               shout
);
    localparam int GRP = (SHAMT_W + STAGES - 1) / STAGES;

    function automatic logic [SHAMT_W-1:0] grp_mask(input int k);
        logic [SHAMT_W-1:0] mk;
        mk = '0;
        for (int i = 0; i < SHAMT_W; i++) mk[i] = (i >= k * GRP) && (i < (k + 1) * GRP);
        return mk;
    endfunction

    logic [STAGES-1:0]              vld_q, vld_d, sh_q, sh_d;
    logic [STAGES-1:0][WIDTH-1:0]   data_q, data_d;
    logic [STAGES-1:0][SHAMT_W-1:0] amt_q, amt_d;
    logic [STAGES-1:0][1:0]         mode_q, mode_d;
    logic                           advance, v, s, ns;
    logic [WIDTH-1:0]               d, nd, rl, rr, ar;
    logic [2*WIDTH-1:0]             dl, dr;
    logic [SHAMT_W-1:0]             a, b;
    logic [1:0]                     md;

    assign out_valid = vld_q[STAGES-1];
    assign r         = data_q[STAGES-1];
    assign shout     = sh_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Left modes lose the bit that a rotate-left brings to bit 0; right modes the one a rotate-right brings to the MSB.
    always_comb begin
        v = in_valid;
        d = m;
        a = amount;
        md = mode;
        s = 1'b0;
        b = '0;
        dl = '0;
        dr = '0;
        rl = '0;
        rr = '0;
        ar = '0;
        nd = '0;
        ns = 1'b0;
        vld_d = vld_q;
        sh_d = sh_q;
        data_d = data_q;
        amt_d = amt_q;
        mode_d = mode_q;
        for (int k = 0; k < STAGES; k++) begin
            b = a & grp_mask(k);
            dl = {d, d} << b;
            dr = {d, d} >> b;
            rl = dl[2*WIDTH-1:WIDTH];
            rr = dr[WIDTH-1:0];
            ar = $signed(d) >>> b;
            nd = md == 2'b00 ? rl : md == 2'b01 ? d << b : md == 2'b10 ? d >> b : ar;
            ns = b == '0 ? s : md[1] ? rr[WIDTH-1] : rl[0];
            if (advance) begin
                vld_d[k] = v;
                if (v) begin
                    data_d[k] = nd;
                    sh_d[k] = ns;
                    amt_d[k] = a;
                    mode_d[k] = md;
                end
            end
            v = vld_q[k];
            d = data_q[k];
            a = amt_q[k];
            md = mode_q[k];
            s = sh_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            sh_q <= '0;
            data_q <= '0;
            amt_q <= '0;
            mode_q <= '0;
        end else begin
            vld_q <= vld_d;
            sh_q <= sh_d;
            data_q <= data_d;
            amt_q <= amt_d;
            mode_q <= mode_d;
        end
    end
endmodule

// File: tb/tb_shift_rotate_pipe.sv
// tb_shift_rotate_pipe: directed checks of shift_rotate_pipe plus a width/depth sweep against a bitwise reference
module tb_shift_rotate_pipe;
    logic        clk = 1'b0;
    logic        reset, iv, ir, ov, ordy, sh;
    logic [31:0] m, r;
    logic [4:0]  amt;
    logic [1:0]  mode;
    logic        iv16, ir16, ov16, sh16, iv64, ir64, ov64, sh64;
    logic [15:0] r16;
    logic [63:0] sm, r64;
    logic [5:0]  sa;
    logic [1:0]  smode;
    logic [31:0] expv [6];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    shift_rotate_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .m(m), .amount(amt), .mode(mode),
        .out_valid(ov), .out_ready(ordy), .r(r), .shout(sh)
    );
    shift_rotate_pipe #(.WIDTH(16), .STAGES(1)) d16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .m(sm[15:0]), .amount(sa[3:0]), .mode(smode),
        .out_valid(ov16), .out_ready(1'b1), .r(r16), .shout(sh16)
    );
    shift_rotate_pipe #(.WIDTH(64), .STAGES(6)) d64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .m(sm), .amount(sa), .mode(smode),
        .out_valid(ov64), .out_ready(1'b1), .r(r64), .shout(sh64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [64:0] ref_shift(input int w, input logic [63:0] mv, input int a, input logic [1:0] md);
        logic [63:0] o;
        logic        c;
        o = '0;
        for (int i = 0; i < w; i++)
            case (md)
                2'b00:   o[i] = mv[(i - a + w) % w];
                2'b01:   o[i] = i >= a ? mv[i - a] : 1'b0;
                2'b10:   o[i] = i + a < w ? mv[i + a] : 1'b0;
                default: o[i] = i + a < w ? mv[i + a] : mv[w - 1];
            endcase
        c = a == 0 ? 1'b0 : md == 2'b00 ? o[0] : md == 2'b01 ? mv[w - a] : mv[a - 1];
        return {c, o};
    endfunction

    task automatic op32(input logic [31:0] mv, input int a, input logic [1:0] md, input logic [31:0] er, input logic esh);
        int lat;
        m = mv;
        amt = 5'(a);
        mode = md;
        iv = 1'b1;
        ordy = 1'b1;
        #1 chk("acc_ready", ir, 1);
        @(negedge clk);
        iv = 1'b0;
        lat = 1;
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        chk($sformatf("r_%h_%0d_%0d", mv, a, md), r, er);
        chk($sformatf("shout_%h_%0d_%0d", mv, a, md), sh, esh);
        @(negedge clk);
    endtask

    task automatic sweep(input int w, input logic [63:0] mv, input int a, input logic [1:0] md);
        logic [64:0] e;
        int          lat, st;
        st = w == 16 ? 1 : 6;
        e = ref_shift(w, mv, a, md);
        sm = mv;
        sa = 6'(a);
        smode = md;
        if (w == 16) iv16 = 1'b1;
        else iv64 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        iv64 = 1'b0;
        lat = 1;
        while (!(w == 16 ? ov16 : ov64) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("sw%0d_lat", w), lat, st);
        chk($sformatf("sw%0d_r_%h_%0d_%0d", w, mv, a, md), w == 16 ? {48'b0, r16} : r64, e[63:0]);
        chk($sformatf("sw%0d_sh_%h_%0d_%0d", w, mv, a, md), w == 16 ? sh16 : sh64, e[64]);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, got, stall, cyc;
        bit seen;
        expv = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20};
        reset = 1'b1;
        iv = 1'b0;
        iv16 = 1'b0;
        iv64 = 1'b0;
        ordy = 1'b1;
        m = '0;
        amt = '0;
        mode = '0;
        sm = '0;
        sa = '0;
        smode = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", ov, 0);
        chk("rst_r", r, 0);
        chk("rst_shout", sh, 0);
        chk("rst_in_ready", ir, 1);
        chk("rst_ov16", ov16, 0);
        chk("rst_ov64", ov64, 0);
        @(negedge clk);

        op32(32'h80000001, 1, 2'b00, 32'h00000003, 1'b1);
        op32(32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF, 1'b0);
        op32(32'h000000F0, 4, 2'b10, 32'h0000000F, 1'b0);
        op32(32'h000000F0, 5, 2'b10, 32'h00000007, 1'b1);
        op32(32'hC0000000, 1, 2'b01, 32'h80000000, 1'b1);
        op32(32'h80000000, 31, 2'b11, 32'hFFFFFFFF, 1'b0);
        op32(32'h7FFFFFFF, 31, 2'b11, 32'h00000000, 1'b1);
        op32(32'h12345678, 4, 2'b00, 32'h23456781, 1'b1);
        op32(32'h00000001, 31, 2'b00, 32'h80000000, 1'b0);
        op32(32'h00000001, 31, 2'b01, 32'h80000000, 1'b0);
        op32(32'h80000000, 31, 2'b10, 32'h00000001, 1'b0);
        op32(32'hF0000000, 4, 2'b11, 32'hFF000000, 1'b0);
        op32(32'h8000000F, 1, 2'b11, 32'hC0000007, 1'b1);
        op32(32'hDEADBEEF, 0, 2'b11, 32'hDEADBEEF, 1'b0);

        sent = 0;
        got = 0;
        stall = 0;
        cyc = 0;
        seen = 1'b0;
        m = 32'h1;
        mode = 2'b00;
        while (got < 6 && cyc < 60) begin
            iv = sent < 6;
            amt = 5'(sent);
            if (ov && !seen) begin
                seen = 1'b1;
                stall = 5;
            end
            ordy = stall == 0;
            #1;
            if (stall > 0) begin
                chk("bp_ready_low", ir, 0);
                chk("bp_hold", r, 32'h1);
                stall--;
            end
            if (ov && ordy) begin
                chk($sformatf("bp_order%0d", got), r, expv[got]);
                got++;
            end
            if (iv && ir) sent++;
            @(negedge clk);
            cyc++;
        end
        iv = 1'b0;
        ordy = 1'b1;
        chk("bp_count", got, 6);
        repeat (3) begin
            #1 chk("bp_nodup", ov, 0);
            @(negedge clk);
        end

        mode = 2'b01;
        m = 32'h000000A5;
        amt = 5'd3;
        iv = 1'b1;
        ordy = 1'b0;
        @(negedge clk);
        amt = 5'd4;
        @(negedge clk);
        reset = 1'b1;
        amt = 5'd5;
        @(negedge clk);
        reset = 1'b0;
        iv = 1'b0;
        ordy = 1'b1;
        #1;
        chk("mid_rst_in_ready", ir, 1);
        chk("mid_rst_r", r, 0);
        repeat (4) begin
            #1 chk("mid_rst_no_out", ov, 0);
            @(negedge clk);
        end

        sweep(16, 64'h000000000000BEEF, 0, 2'b11);
        sweep(16, 64'h0000000000008001, 15, 2'b11);
        sweep(16, 64'h0000000000000003, 15, 2'b00);
        sweep(64, 64'h8000000000000000, 63, 2'b11);
        sweep(64, 64'h0123456789ABCDEF, 63, 2'b01);
        sweep(64, 64'h0123456789ABCDEF, 0, 2'b10);
        for (int i = 0; i < 8; i++) sweep(16, {$urandom, $urandom}, $urandom_range(15), 2'($urandom_range(3)));
        for (int i = 0; i < 8; i++) sweep(64, {$urandom, $urandom}, $urandom_range(63), 2'($urandom_range(3)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
